cpu_alu: RTL and testbench

8-bit registered arithmetic/logic unit for the NES 6502-compatible CPU core. It performs add-with-carry, subtract-with-borrow, AND, OR, EOR and shift-right on two 8-bit operands. It returns the result together with the carry, overflow, zero and sign flags, which the CPU routes into status register P (bits 0, 6, 1, 7). The CPU drives the mode from the decoded instruction.

---
 rtl/cpu_alu.sv | 96 +++++++++
 tb/tb_cpu_alu.sv | 84 ++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// 8-bit registered ALU for the 6502-compatible core: ADC, SBC, AND, ORA, EOR, LSR/ROR.
// Result and C/V/Z/N flags are registered; latency one cycle, one operation per cycle.
module cpu_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign
);

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_AND = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_EOR = 5'd3;
  localparam logic [4:0] ALU_SR  = 5'd4;
  localparam logic [4:0] ALU_SUB = 5'd5;

  logic       w_is_sub;
  logic [7:0] w_b_eff;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_c;
  logic       w_v;

  logic [7:0] r_out;
  logic       r_c;
  logic       r_v;
  logic       r_z;
  logic       r_n;

  // SBC is ADC of the complemented operand; carry_in=1 means no borrow.
  assign w_is_sub = (mode == ALU_SUB);
  assign w_b_eff  = w_is_sub ? ~alu_b : alu_b;
  assign w_sum    = {1'b0, alu_a} + {1'b0, w_b_eff} + {8'b0, carry_in};

  always_comb begin
    w_res = w_sum[7:0];
    w_c   = w_sum[8];
    w_v   = (alu_a[7] == alu_b[7]) && (w_sum[7] != alu_a[7]);
    unique case (mode)
      ALU_AND: begin
        w_res = alu_a & alu_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      ALU_OR: begin
        w_res = alu_a | alu_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      ALU_EOR: begin
        w_res = alu_a ^ alu_b;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      ALU_SR: begin
        w_res = {carry_in, alu_a[7:1]};
        w_c   = alu_a[0];
        w_v   = 1'b0;
      end
      ALU_SUB: begin
        w_v = (alu_a[7] != alu_b[7]) && (w_sum[7] != alu_a[7]);
      end
      default: ;  // ALU_ADD and every unused encoding behave as ADD
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 8'h00;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else begin
      r_out <= w_res;
      r_c   <= w_c;
      r_v   <= w_v;
      r_z   <= (w_res == 8'h00);
      r_n   <= w_res[7];
    end
  end

  assign alu_out   = r_out;
  assign carry_out = r_c;
  assign overflow  = r_v;
  assign zero      = r_z;
  assign sign      = r_n;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed bench for cpu_alu: hand-computed vectors checked one cycle after each edge.
module tb_cpu_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] mode;
  logic       carry_in;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       sign;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_alu dut (
    .clk       (clk),
    .rst       (rst),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .mode      (mode),
    .carry_in  (carry_in),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  // Present one vector, clock it in, then compare {out,C,V,Z,N} just after the edge.
  task automatic step(input string tag, input logic r, input logic [4:0] m,
                      input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] e_out, input logic e_c, input logic e_v,
                      input logic e_z, input logic e_n);
    logic [11:0] obs;
    logic [11:0] exp;
    rst      = r;
    mode     = m;
    alu_a    = a;
    alu_b    = b;
    carry_in = ci;
    @(posedge clk);
    #1;
    obs = {alu_out, carry_out, overflow, zero, sign};
    exp = {e_out, e_c, e_v, e_z, e_n};
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed out=%h CVZN=%b expected out=%h CVZN=%b",
             tag, obs[11:4], obs[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  initial begin
    //        tag            rst mode   a      b      ci   out    C     V     Z     N
    step("reset",         1, 5'd0, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("add_ovf",       0, 5'd0, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("add_carry_z",   0, 5'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step("add_cin",       0, 5'd0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sub_borrow_v",  0, 5'd5, 8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("sub_noborrow",  0, 5'd5, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sub_borrow_in", 0, 5'd5, 8'h00, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    step("and",           0, 5'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or",            0, 5'd2, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    step("eor_zero",      0, 5'd3, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("eor_neg",       0, 5'd3, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    step("sr_ror",        0, 5'd4, 8'h81, 8'h55, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sr_lsr_zero",   0, 5'd4, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step("mode7_add",     0, 5'd7, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mode6_negovf",  0, 5'd6, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step("mode31_add",    0, 5'd31, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rst_priority",  1, 5'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset",    0, 5'd0, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    step("flags_clear",   0, 5'd2, 8'h01, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
